// File: rtl/nwr_pkg.sv
// Shared types and constants for the neighbourhood window reader:
// FSM state encoding, line-buffer geometry and slot addressing.
package nwr_pkg;

    localparam int NUM_SLOTS  = 4;
    localparam int RAM_ADDR_W = 9;

    typedef enum logic [3:0] {
        IDLE,
        WAIT,
        RD0,
        RD1,
        RD2,
        SHIFT,
        PRESENT,
        ROWEND,
        FLUSH
    } nwr_state_e;

    typedef logic [$clog2(NUM_SLOTS)-1:0] slot_t;

    function automatic logic [RAM_ADDR_W-1:0] slot_base(input slot_t slot, input int unsigned width);
        return RAM_ADDR_W'(slot) * RAM_ADDR_W'(width);
    endfunction

endpackage

// File: rtl/nwr_window_regs.sv
// 3x3 pixel window held as a row-major shift register. A column is assembled
// from top/middle captures plus the bottom pixel, then shifted in on the right.
module nwr_window_regs #(
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load_top,
    input  logic               load_mid,
    input  logic               shift,
    input  logic [PIX_W-1:0]   pix,
    output logic [9*PIX_W-1:0] window
);

    logic [8:0][PIX_W-1:0] taps;
    logic [PIX_W-1:0]      col_top;
    logic [PIX_W-1:0]      col_mid;

    assign window = taps;

    // NOTE: the window is reset even though it is storage, because its value is a visible output after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps    <= '0;
            col_top <= '0;
            col_mid <= '0;
        end else begin
            // NOTE: non-blocking assignments let every tap read its neighbour's old value in the same shift.
            if (load_top) col_top <= pix;
            if (load_mid) col_mid <= pix;
            if (clear) begin
                taps <= '0;
            end else if (shift) begin
                for (int r = 0; r < 3; r++) begin
                    taps[r*3+0] <= taps[r*3+1];
                    taps[r*3+1] <= taps[r*3+2];
                end
                taps[2] <= col_top;
                taps[5] <= col_mid;
                taps[8] <= pix;
            end
        end
    end

endmodule

// File: rtl/neighbourhood_window_reader.sv
// Reads three line-buffer rows per column from a 4-slot circular RAM and emits
// 3x3 windows with valid/ready. Define NWR_ZERO_PAD_EN to also emit zero-padded border windows.
module neighbourhood_window_reader
    import nwr_pkg::*;
#(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128,
    parameter int PIX_W      = 8
) (
    input  logic                  readClk,
    input  logic                  resetRd,
    input  logic                  start,
    input  logic                  lineDone,
    output logic                  lineFree,
    output logic                  rdEn,
    output logic [RAM_ADDR_W-1:0] readAddress,
    input  logic [PIX_W-1:0]      rdData,
    output logic                  winValid,
    input  logic                  winReady,
    output logic [9*PIX_W-1:0]    window,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  lineOverflow
);

    localparam int XW = $clog2(IMG_WIDTH + 1);
    localparam int YW = $clog2(IMG_HEIGHT);

`ifdef NWR_ZERO_PAD_EN
    localparam logic [XW-1:0] X_END         = XW'(IMG_WIDTH);
    localparam logic [XW-1:0] X_FIRST_WIN   = XW'(1);
    localparam logic [YW-1:0] Y_FIRST       = '0;
    localparam logic [YW-1:0] Y_LAST        = YW'(IMG_HEIGHT - 1);
    localparam slot_t         TOP_SLOT_INIT = slot_t'(NUM_SLOTS - 1);
    localparam int            FLUSH_FREES   = 2;
`else
    localparam logic [XW-1:0] X_END         = XW'(IMG_WIDTH - 1);
    localparam logic [XW-1:0] X_FIRST_WIN   = XW'(2);
    localparam logic [YW-1:0] Y_FIRST       = YW'(1);
    localparam logic [YW-1:0] Y_LAST        = YW'(IMG_HEIGHT - 2);
    localparam slot_t         TOP_SLOT_INIT = '0;
    localparam int            FLUSH_FREES   = 3;
`endif
    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_FREES - 1);

    nwr_state_e            state, next_state;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    slot_t                 top_slot, rd_slot, rd_row;
    logic [1:0]            flush_cnt;
    logic [2:0]            lines_avail, need_lines;
    logic                  free_now, last_free;
    logic                  rd_active, row_zero, cap_zero;
    logic                  top_zero, bot_zero, col_zero, row_free, win_clear;
    logic                  load_top, load_mid, shift;
    logic [RAM_ADDR_W-1:0] rd_addr, last_addr;

`ifdef NWR_ZERO_PAD_EN
    // Out-of-frame taps are forced to zero instead of being read.
    assign top_zero   = (y == Y_FIRST);
    assign bot_zero   = (y == Y_LAST);
    assign col_zero   = (x == X_END);
    assign need_lines = (top_zero || bot_zero) ? 3'd2 : 3'd3;
    assign row_free   = (y != Y_FIRST);
    assign win_clear  = (state == WAIT);
`else
    assign top_zero   = 1'b0;
    assign bot_zero   = 1'b0;
    assign col_zero   = 1'b0;
    assign need_lines = 3'd3;
    assign row_free   = 1'b1;
    assign win_clear  = 1'b0;
`endif

    always_ff @(posedge readClk or posedge resetRd) begin
        if (resetRd) state <= IDLE;
        else         state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = WAIT;
            WAIT:    if (lines_avail >= need_lines) next_state = RD0;
            RD0:     next_state = RD1;
            RD1:     next_state = RD2;
            RD2:     next_state = SHIFT;
            SHIFT:   next_state = (x >= X_FIRST_WIN) ? PRESENT : RD0;
            PRESENT: if (winReady) next_state = (x < X_END) ? RD0 : ROWEND;
            ROWEND:  next_state = (y < Y_LAST) ? WAIT : FLUSH;
            FLUSH:   if (flush_cnt == FLUSH_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rd_active = 1'b0;
        rd_row    = '0;
        row_zero  = 1'b0;
        cap_zero  = 1'b0;
        load_top  = 1'b0;
        load_mid  = 1'b0;
        shift     = 1'b0;
        winValid  = 1'b0;
        free_now  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            RD0:     begin rd_active = 1'b1; rd_row = 2'd0; row_zero = top_zero; end
            RD1:     begin rd_active = 1'b1; rd_row = 2'd1; load_top = 1'b1; cap_zero = top_zero | col_zero; end
            RD2:     begin rd_active = 1'b1; rd_row = 2'd2; row_zero = bot_zero; load_mid = 1'b1; cap_zero = col_zero; end
            SHIFT:   begin shift = 1'b1; cap_zero = bot_zero | col_zero; end
            PRESENT: winValid = 1'b1;
            ROWEND:  free_now = (y < Y_LAST) && row_free;
            FLUSH:   free_now = 1'b1;
            default: ;
        endcase
    end

    // Address is live only while reading; otherwise the last issued address is held.
    assign rd_slot     = top_slot + rd_row;
    assign rd_addr     = slot_base(rd_slot, IMG_WIDTH) + RAM_ADDR_W'(x);
    assign rdEn        = rd_active && !row_zero && !col_zero;
    assign readAddress = rdEn ? rd_addr : last_addr;

    always_ff @(posedge readClk or posedge resetRd) begin
        if (resetRd) begin
            x         <= '0;
            y         <= '0;
            top_slot  <= '0;
            flush_cnt <= '0;
            last_addr <= '0;
        end else begin
            if (rdEn) last_addr <= rd_addr;
            case (state)
                IDLE: if (start) begin
                    y        <= Y_FIRST;
                    top_slot <= TOP_SLOT_INIT;
                end
                WAIT:    x <= '0;
                SHIFT:   if (x < X_FIRST_WIN) x <= x + XW'(1);
                PRESENT: if (winReady && x < X_END) x <= x + XW'(1);
                ROWEND: begin
                    flush_cnt <= '0;
                    if (y < Y_LAST) begin
                        y        <= y + YW'(1);
                        top_slot <= top_slot + slot_t'(1);
                    end
                end
                FLUSH:   flush_cnt <= flush_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    // Credits track lines written but not yet released; the counter moves on the
    // internal release so WAIT never sees a stale count.
    always_ff @(posedge readClk or posedge resetRd) begin
        if (resetRd) begin
            lines_avail  <= '0;
            lineOverflow <= 1'b0;
            lineFree     <= 1'b0;
            last_free    <= 1'b0;
            frameDone    <= 1'b0;
        end else begin
            lineFree  <= free_now;
            last_free <= (state == FLUSH) && (flush_cnt == FLUSH_LAST);
            frameDone <= last_free;
            if (lineDone && !free_now) begin
                if (lines_avail == 3'(NUM_SLOTS)) lineOverflow <= 1'b1;
                else                              lines_avail  <= lines_avail + 3'd1;
            end else if (!lineDone && free_now) begin
                lines_avail <= lines_avail - 3'd1;
            end
        end
    end

    nwr_window_regs #(.PIX_W(PIX_W)) u_window_regs (
        .clk      (readClk),
        .rst      (resetRd),
        .clear    (win_clear),
        .load_top (load_top),
        .load_mid (load_mid),
        .shift    (shift),
        .pix      (cap_zero ? '0 : rdData),
        .window   (window)
    );

endmodule
